qcnot_exec_reg: RTL

- 5-bit reversible state register wrapped around the qcnot fan-out CNOT stage.
- Drives the stage's input from its held state and captures the stage's output on each forward operation; a reverse operation re-applies the gate to undo the last forward step.
- Keeps a bounded history of pre-gate states, so every undo is checked against the recorded state. Errors are reported, not silently absorbed.

---
 rtl/qcnot_exec_reg.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/qcnot_exec_reg.sv
// rtl/qcnot_exec_reg.sv - reversible 5-bit state register around the qcnot fan-out CNOT stage
//
// Holds a WIDTH-bit state that feeds an external combinational qcnot stage
// through gate_in and takes the stage's result back on gate_out. A forward
// operation records the pre-gate state in a circular history and latches the
// gate result. A reverse operation re-applies the self-inverse gate and checks
// the result against the popped history entry. Any mismatch raises a sticky
// err flag.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   load_valid, load_data  single-cycle load of a new state (honoured in IDLE only)
//   op_valid, op_dir       gate-operation request, 0 = forward, 1 = reverse
//   op_ready               operation can be accepted this cycle
//   gate_in / gate_out     drive to / return from the qcnot stage
//   state                  current register value
//   done, rej              one-cycle completion pulse; rej flags a rejected op
//   err                    sticky reversibility-check failure
//   op_count               net forward minus reverse count, mod 2^CNT_W
//   hist_level             number of valid history entries

module qcnot_exec_reg #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_valid,
    input  logic [WIDTH-1:0]         load_data,
    input  logic                     op_valid,
    input  logic                     op_dir,
    output logic                     op_ready,
    output logic [WIDTH-1:0]         gate_in,
    input  logic [WIDTH-1:0]         gate_out,
    output logic [WIDTH-1:0]         state,
    output logic                     done,
    output logic                     rej,
    output logic                     err,
    output logic [CNT_W-1:0]         op_count,
    output logic [$clog2(DEPTH):0]   hist_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_APPLY = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    logic [1:0]       fsm;
    logic             dir_q;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_top;
    logic [WIDTH-1:0] hist [DEPTH];
    logic [WIDTH-1:0] hist_top;
    logic             hist_empty;
    logic             push;

    // The history is a circular stack: ptr always points at the next slot to
    // write, so the most recent entry sits one below it. When the stack is
    // full, ptr has wrapped onto the oldest entry and a push overwrites it.
    assign ptr_top    = ptr - PW'(1);
    assign hist_top   = hist[ptr_top];
    assign hist_empty = (hist_level == '0);
    assign push       = (fsm == S_APPLY) && !dir_q;

    assign op_ready = (fsm == S_IDLE) && !load_valid;
    assign gate_in  = state;

    // History storage needs no reset: entries are only read while
    // hist_level says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            hist[ptr] <= state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm        <= S_IDLE;
            dir_q      <= 1'b0;
            ptr        <= '0;
            state      <= '0;
            hist_level <= '0;
            op_count   <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
            rej        <= 1'b0;
        end else begin
            // done/rej are pulses: raised on the APPLY edge so they are
            // visible for exactly the RESP cycle.
            done <= 1'b0;
            rej  <= 1'b0;

            case (fsm)
                S_IDLE: begin
                    if (load_valid) begin
                        // A load takes priority over a concurrent op request;
                        // op_ready is already low in that case.
                        state      <= load_data;
                        ptr        <= '0;
                        hist_level <= '0;
                        op_count   <= '0;
                        err        <= 1'b0;
                    end else if (op_valid) begin
                        dir_q <= op_dir;
                        fsm   <= S_APPLY;
                    end
                end

                S_APPLY: begin
                    fsm  <= S_RESP;
                    done <= 1'b1;
                    if (!dir_q) begin
                        state    <= gate_out;
                        ptr      <= ptr + PW'(1);
                        op_count <= op_count + CNT_W'(1);
                        if (hist_level != LEVEL_FULL) begin
                            hist_level <= hist_level + LW'(1);
                        end
                    end else if (hist_empty) begin
                        rej <= 1'b1;
                    end else begin
                        // The gate is its own inverse, so re-applying it must
                        // reproduce the recorded pre-gate state. The result is
                        // taken regardless; a mismatch is only reported.
                        state      <= gate_out;
                        ptr        <= ptr_top;
                        hist_level <= hist_level - LW'(1);
                        op_count   <= op_count - CNT_W'(1);
                        if (gate_out != hist_top) begin
                            err <= 1'b1;
                        end
                    end
                end

                S_RESP: begin
                    fsm <= S_IDLE;
                end

                default: begin
                    fsm <= S_IDLE;
                end
            endcase
        end
    end

endmodule
